mc_ctrl_fsm: RTL and testbench
==============================

Name: mc_ctrl_fsm

Overview:
- Multicycle MIPS control unit and the producing end of the ALU's `alu_ctrl` interface.
- Sequences fetch, decode, execute, memory and writeback for one instruction at a time.
- Drives datapath muxes and enables plus the 4-bit ALU operation code; consumes the ALU's `zero` and `overflow` flags.
- Sits between the instruction register and a shared single-port instruction/data memory that uses a request/ready handshake.

Parameters:
- ALU_CTRL_W, 4, width of the ALU operation code (fixed by the ALU encoding)
- EXC_VECTOR_SEL, 2'b11, `pc_src` value that selects the exception vector

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- opcode  in  6  IR[31:26], valid from DECODE onward
- funct  in  6  IR[5:0]
- zero  in  1  ALU result == 0
- overflow  in  1  ALU signed overflow
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request; held until `mem_ready`
- mem_we  out  1  write request (valid while `mem_req`)
- iord  out  1  0 = PC address, 1 = ALUOut address
- ir_write  out  1  load IR
- reg_write  out  1  register file write enable
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  00 = B, 01 = 4, 10 = sign-extended imm, 11 = sign-extended imm<<2; zero-extended imm for andi/ori
- pc_src  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target, 11 = exception vector
- pc_en  out  1  PC load (already qualified by branch condition)
- alu_ctrl  out  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SRL, 0110 SUB, 0111 SLT, 1100 NOR
- exc  out  1  one-cycle pulse: overflow trap or illegal instruction

Behaviour:
- Reset: state = FETCH. While `rst`=1, every output is 0. The first request is issued in the cycle after `rst` falls.
- Control outputs are decoded from the state register (Moore). Exceptions: `pc_en` and `ir_write` are qualified combinationally by `mem_ready`/`zero` as noted below.
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_ctrl`=ADD.
  - When `mem_ready`=1: `ir_write`=1, `pc_en`=1 (`pc_src`=00), go to DECODE.
  - Otherwise stay in FETCH with outputs stable.
- DECODE: ALU computes the branch target (`alu_src_a`=0, `alu_src_b`=11, ADD). Next state by opcode:
  - 00h → REXEC
  - 23h/2Bh → MEMADR
  - 04h/05h → BRANCH
  - 08h/09h/0Ch/0Dh/0Ah → IEXEC
  - 02h → JUMP
  - else → TRAP
- REXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_ctrl` from funct:
  - 20h/21h ADD; 22h/23h SUB; 24h AND; 25h OR; 27h NOR; 2Ah SLT; 00h SLL; 02h SRL
  - any other funct → TRAP
  - Next state RWB, unless funct is 20h or 22h and `overflow`=1 → TRAP.
- RWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0 → FETCH.
- MEMADR: A + sign-extended imm (ADD) → MEMRD for lw, MEMWR for sw.
- MEMRD: `mem_req`=1, `iord`=1; stay until `mem_ready`, then → MEMWB.
- MEMWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1 → FETCH.
- MEMWR: `mem_req`=1, `mem_we`=1, `iord`=1; stay until `mem_ready`, then → FETCH.
- BRANCH: SUB on A/B, `pc_src`=01. `pc_en` = `zero` for beq, ~`zero` for bne. → FETCH.
- IEXEC: `alu_src_a`=1, `alu_src_b`=10. `alu_ctrl`:
  - addi/addiu ADD; andi AND; ori OR; slti SLT
  - → IWB, unless addi with `overflow`=1 → TRAP.
- IWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0 → FETCH.
- JUMP: `pc_src`=10, `pc_en`=1 → FETCH.
- TRAP: `exc`=1, `pc_src`=EXC_VECTOR_SEL, `pc_en`=1, no `reg_write` → FETCH.
- Latency with `mem_ready` tied high:
  - R-type/I-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq/bne: 3 cycles
  - j: 3 cycles
  - trap: 3 cycles, or 4 cycles for a REXEC/IEXEC overflow trap
- `mem_req` never drops before `mem_ready`; `mem_we` and `iord` are constant during a wait.
- `rst` asserted mid-instruction or mid-wait: next state FETCH; the pending request is abandoned (memory must tolerate `mem_req` falling).
- `reg_write` and `mem_we` are never asserted in the same cycle, and never in TRAP.

Decomposition:
- Shared package mips_pkg holds:
  - the state enumeration
  - opcode and funct constants
  - the `alu_ctrl` code constants (shared with the ALU)
  - the `alu_src_b` and `pc_src` encodings
- One natural sub-module: alu_dec. It is combinational: (state class, opcode, funct) → `alu_ctrl` plus an illegal-funct flag.

Test Plan:
- add (opcode 00h, funct 20h), `mem_ready`=1 → states FETCH/DECODE/REXEC/RWB; `alu_ctrl`=0010 in REXEC; `reg_write`=1 with `reg_dst`=1 in cycle 4; `exc`=0.
- lw (23h) with `mem_ready` low for 3 cycles in MEMRD → `mem_req`=1, `iord`=1 held 4 cycles; MEMWB `reg_write`=1, `mem_to_reg`=1; 8 cycles total.
- beq with `zero`=1 → `pc_en`=1, `pc_src`=01 in BRANCH; bne with `zero`=1 → `pc_en`=0.
- addi with `overflow`=1 in IEXEC → TRAP next cycle: `exc`=1, `pc_src`=11, `pc_en`=1; no `reg_write` pulse.
- Illegal opcode 3Fh, or funct 3Fh under opcode 00h → TRAP with one `exc` pulse, then FETCH.
- `rst` asserted during MEMWR wait → all outputs 0 next cycle; FETCH `mem_req` the cycle after `rst` falls.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared multicycle MIPS definitions: FSM states, instruction fields, ALU codes
// and datapath mux encodings used by the controller and the ALU.
package mips_pkg;

    localparam int unsigned ALU_CTRL_W = 4;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_REXEC,
        S_RWB,
        S_MEMADR,
        S_MEMRD,
        S_MEMWB,
        S_MEMWR,
        S_BRANCH,
        S_IEXEC,
        S_IWB,
        S_JUMP,
        S_TRAP
    } state_e;

    typedef enum logic [1:0] {
        CLS_ADD,
        CLS_SUB,
        CLS_RTYPE,
        CLS_ITYPE
    } alu_cls_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLL = 4'b0011;
    localparam logic [ALU_CTRL_W-1:0] ALU_SRL = 4'b0100;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [1:0] ASB_B      = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;

    // Which operation family the ALU decoder should use in a given state.
    function automatic alu_cls_e state_class(state_e s);
        case (s)
            S_REXEC:  return CLS_RTYPE;
            S_IEXEC:  return CLS_ITYPE;
            S_BRANCH: return CLS_SUB;
            default:  return CLS_ADD;
        endcase
    endfunction

endpackage

// File: rtl/mc_ctrl_fsm_if.sv
// Control/status bundle between the multicycle controller (master) and the
// datapath, ALU and shared memory (slave).
interface mc_ctrl_fsm_if;
    import mips_pkg::*;

    logic [5:0]            opcode;
    logic [5:0]            funct;
    logic                  zero;
    logic                  overflow;
    logic                  mem_ready;
    logic                  mem_req;
    logic                  mem_we;
    logic                  iord;
    logic                  ir_write;
    logic                  reg_write;
    logic                  reg_dst;
    logic                  mem_to_reg;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic                  pc_en;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  exc;

    modport master (
        input  opcode, funct, zero, overflow, mem_ready,
        output mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl, exc
    );

    modport slave (
        output opcode, funct, zero, overflow, mem_ready,
        input  mem_req, mem_we, iord, ir_write, reg_write, reg_dst, mem_to_reg,
               alu_src_a, alu_src_b, pc_src, pc_en, alu_ctrl, exc
    );

endinterface

// File: rtl/mc_ctrl_fsm_alu_dec.sv
// ALU operation decoder: maps the controller's state class plus opcode/funct
// to an ALU code, flagging R-type funct values the ALU cannot execute.
module alu_dec
    import mips_pkg::*;
(
    input  alu_cls_e               cls,
    input  logic [5:0]             opcode,
    input  logic [5:0]             funct,
    output logic [ALU_CTRL_W-1:0]  alu_ctrl,
    output logic                   illegal_funct
);

    always_comb begin
        alu_ctrl      = ALU_ADD;
        illegal_funct = 1'b0;
        case (cls)
            CLS_SUB: alu_ctrl = ALU_SUB;
            CLS_RTYPE: begin
                case (funct)
                    F_ADD, F_ADDU: alu_ctrl = ALU_ADD;
                    F_SUB, F_SUBU: alu_ctrl = ALU_SUB;
                    F_AND:         alu_ctrl = ALU_AND;
                    F_OR:          alu_ctrl = ALU_OR;
                    F_NOR:         alu_ctrl = ALU_NOR;
                    F_SLT:         alu_ctrl = ALU_SLT;
                    F_SLL:         alu_ctrl = ALU_SLL;
                    F_SRL:         alu_ctrl = ALU_SRL;
                    default:       illegal_funct = 1'b1;
                endcase
            end
            CLS_ITYPE: begin
                case (opcode)
                    OP_ANDI: alu_ctrl = ALU_AND;
                    OP_ORI:  alu_ctrl = ALU_OR;
                    OP_SLTI: alu_ctrl = ALU_SLT;
                    default: alu_ctrl = ALU_ADD;
                endcase
            end
            default: alu_ctrl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// Multicycle MIPS control unit: Moore FSM sequencing fetch/decode/execute/
// memory/writeback, with pc_en and ir_write qualified by mem_ready/zero.
module mc_ctrl_fsm
    import mips_pkg::*;
#(
    parameter int unsigned ALU_CTRL_W     = 4,
    parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
    input  logic          clk,
    input  logic          rst,
    mc_ctrl_fsm_if.master bus
);

    state_e                 state_q, state_d;
    logic [ALU_CTRL_W-1:0]  alu_code;
    logic                   illegal_funct;
    logic                   ovf_trap_funct;

    alu_dec u_alu_dec (
        .cls           (state_class(state_q)),
        .opcode        (bus.opcode),
        .funct         (bus.funct),
        .alu_ctrl      (alu_code),
        .illegal_funct (illegal_funct)
    );

    // Only the trapping forms (add/sub) honour overflow; addu/subu ignore it.
    assign ovf_trap_funct = (bus.funct == F_ADD) || (bus.funct == F_SUB);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_FETCH;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_RTYPE:                                 state_d = S_REXEC;
                    OP_LW, OP_SW:                             state_d = S_MEMADR;
                    OP_BEQ, OP_BNE:                           state_d = S_BRANCH;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IEXEC;
                    OP_J:                                     state_d = S_JUMP;
                    default:                                  state_d = S_TRAP;
                endcase
            end
            S_REXEC: begin
                if (illegal_funct || (ovf_trap_funct && bus.overflow)) state_d = S_TRAP;
                else                                                   state_d = S_RWB;
            end
            S_MEMADR: state_d = (bus.opcode == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_IEXEC: begin
                if ((bus.opcode == OP_ADDI) && bus.overflow) state_d = S_TRAP;
                else                                         state_d = S_IWB;
            end
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.iord       = 1'b0;
        bus.ir_write   = 1'b0;
        bus.reg_write  = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.alu_src_a  = 1'b0;
        bus.alu_src_b  = ASB_B;
        bus.pc_src     = PCS_ALU;
        bus.pc_en      = 1'b0;
        bus.alu_ctrl   = alu_code;
        bus.exc        = 1'b0;
        case (state_q)
            S_FETCH: begin
                bus.mem_req   = 1'b1;
                bus.alu_src_b = ASB_FOUR;
                bus.ir_write  = bus.mem_ready;
                bus.pc_en     = bus.mem_ready;
            end
            S_DECODE: bus.alu_src_b = ASB_IMM_SH;
            S_REXEC:  bus.alu_src_a = 1'b1;
            S_RWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_MEMADR: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_IMM;
            end
            S_MEMRD: begin
                bus.mem_req = 1'b1;
                bus.iord    = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_req = 1'b1;
                bus.mem_we  = 1'b1;
                bus.iord    = 1'b1;
            end
            S_BRANCH: begin
                bus.alu_src_a = 1'b1;
                bus.pc_src    = PCS_ALUOUT;
                bus.pc_en     = (bus.opcode == OP_BNE) ? ~bus.zero : bus.zero;
            end
            S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = ASB_IMM;
            end
            S_IWB:  bus.reg_write = 1'b1;
            S_JUMP: begin
                bus.pc_src = PCS_JUMP;
                bus.pc_en  = 1'b1;
            end
            S_TRAP: begin
                bus.exc    = 1'b1;
                bus.pc_src = EXC_VECTOR_SEL;
                bus.pc_en  = 1'b1;
            end
            default: ;
        endcase
        if (rst) begin
            bus.mem_req    = 1'b0;
            bus.mem_we     = 1'b0;
            bus.iord       = 1'b0;
            bus.ir_write   = 1'b0;
            bus.reg_write  = 1'b0;
            bus.reg_dst    = 1'b0;
            bus.mem_to_reg = 1'b0;
            bus.alu_src_a  = 1'b0;
            bus.alu_src_b  = '0;
            bus.pc_src     = '0;
            bus.pc_en      = 1'b0;
            bus.alu_ctrl   = '0;
            bus.exc        = 1'b0;
        end
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: each cycle pushes the expected (masked)
// output vector for the intended state, then checks it at the falling edge.
module tb_mc_ctrl_fsm;

    typedef struct packed {
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic       pc_en;
        logic [3:0] alu_ctrl;
        logic       exc;
    } ov_t;

    typedef struct {
        string tag;
        ov_t   val;
        ov_t   mask;
    } exp_t;

    typedef enum {
        T_FETCH, T_DECODE, T_REXEC, T_RWB, T_MEMADR, T_MEMRD, T_MEMWB,
        T_MEMWR, T_BRANCH, T_IEXEC, T_IWB, T_JUMP, T_TRAP
    } tst_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mc_ctrl_fsm_if bus ();

    mc_ctrl_fsm #(
        .ALU_CTRL_W     (4),
        .EXC_VECTOR_SEL (2'b11)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    function automatic ov_t observe();
        ov_t o;
        o.mem_req    = bus.mem_req;
        o.mem_we     = bus.mem_we;
        o.iord       = bus.iord;
        o.ir_write   = bus.ir_write;
        o.reg_write  = bus.reg_write;
        o.reg_dst    = bus.reg_dst;
        o.mem_to_reg = bus.mem_to_reg;
        o.alu_src_a  = bus.alu_src_a;
        o.alu_src_b  = bus.alu_src_b;
        o.pc_src     = bus.pc_src;
        o.pc_en      = bus.pc_en;
        o.alu_ctrl   = bus.alu_ctrl;
        o.exc        = bus.exc;
        return o;
    endfunction

    // Expected outputs per state, written straight from the control table.
    function automatic exp_t model(tst_e st, logic rdy, logic z,
                                   logic [5:0] op, logic [5:0] fn, string tag);
        exp_t e;
        ov_t  v = '0;
        ov_t  m = '0;
        m.mem_req = 1'b1; m.mem_we = 1'b1; m.ir_write = 1'b1;
        m.reg_write = 1'b1; m.pc_en = 1'b1; m.exc = 1'b1;
        case (st)
            T_FETCH: begin
                v.mem_req = 1'b1; v.alu_src_b = 2'b01; v.alu_ctrl = 4'b0010;
                v.ir_write = rdy; v.pc_en = rdy;
                m.iord = 1'b1; m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_ctrl = 4'hF;
                if (rdy) m.pc_src = 2'b11;
            end
            T_DECODE: begin
                v.alu_src_b = 2'b11; v.alu_ctrl = 4'b0010;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_ctrl = 4'hF;
            end
            T_REXEC: begin
                v.alu_src_a = 1'b1;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11;
                m.alu_ctrl = 4'hF;
                case (fn)
                    6'h20, 6'h21: v.alu_ctrl = 4'b0010;
                    6'h22, 6'h23: v.alu_ctrl = 4'b0110;
                    6'h24:        v.alu_ctrl = 4'b0000;
                    6'h25:        v.alu_ctrl = 4'b0001;
                    6'h27:        v.alu_ctrl = 4'b1100;
                    6'h2A:        v.alu_ctrl = 4'b0111;
                    6'h00:        v.alu_ctrl = 4'b0011;
                    6'h02:        v.alu_ctrl = 4'b0100;
                    default:      m.alu_ctrl = 4'h0;
                endcase
            end
            T_RWB: begin
                v.reg_write = 1'b1; v.reg_dst = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            T_MEMADR: begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10; v.alu_ctrl = 4'b0010;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_ctrl = 4'hF;
            end
            T_MEMRD: begin
                v.mem_req = 1'b1; v.iord = 1'b1; m.iord = 1'b1;
            end
            T_MEMWB: begin
                v.reg_write = 1'b1; v.mem_to_reg = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            T_MEMWR: begin
                v.mem_req = 1'b1; v.mem_we = 1'b1; v.iord = 1'b1; m.iord = 1'b1;
            end
            T_BRANCH: begin
                v.alu_src_a = 1'b1; v.alu_ctrl = 4'b0110; v.pc_src = 2'b01;
                v.pc_en = (op == 6'h05) ? ~z : z;
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_ctrl = 4'hF; m.pc_src = 2'b11;
            end
            T_IEXEC: begin
                v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
                case (op)
                    6'h0C:   v.alu_ctrl = 4'b0000;
                    6'h0D:   v.alu_ctrl = 4'b0001;
                    6'h0A:   v.alu_ctrl = 4'b0111;
                    default: v.alu_ctrl = 4'b0010;
                endcase
                m.alu_src_a = 1'b1; m.alu_src_b = 2'b11; m.alu_ctrl = 4'hF;
            end
            T_IWB: begin
                v.reg_write = 1'b1;
                m.reg_dst = 1'b1; m.mem_to_reg = 1'b1;
            end
            T_JUMP: begin
                v.pc_src = 2'b10; v.pc_en = 1'b1; m.pc_src = 2'b11;
            end
            T_TRAP: begin
                v.exc = 1'b1; v.pc_src = 2'b11; v.pc_en = 1'b1; m.pc_src = 2'b11;
            end
            default: ;
        endcase
        e.tag = tag; e.val = v; e.mask = m;
        return e;
    endfunction

    task automatic check_one();
        exp_t e;
        ov_t  o;
        e = sb.pop_front();
        o = observe();
        checks++;
        assert ((o & e.mask) === (e.val & e.mask)) else begin
            errors++;
            $error("FAIL %s observed=%05h expected=%05h mask=%05h",
                   e.tag, o & e.mask, e.val & e.mask, e.mask);
        end
    endtask

    task automatic cyc(input tst_e st, input logic rdy, input logic z, input logic ovf,
                       input logic [5:0] op, input logic [5:0] fn, input string tag);
        rst           = 1'b0;
        bus.mem_ready = rdy;
        bus.zero      = z;
        bus.overflow  = ovf;
        bus.opcode    = op;
        bus.funct     = fn;
        sb.push_back(model(st, rdy, z, op, fn, tag));
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    task automatic rst_cyc(input string tag);
        exp_t e;
        rst           = 1'b1;
        bus.mem_ready = 1'b1;
        bus.zero      = 1'b1;
        bus.overflow  = 1'b1;
        bus.opcode    = 6'($urandom);
        bus.funct     = 6'($urandom);
        e.tag = tag; e.val = '0; e.mask = '1;
        sb.push_back(e);
        @(negedge clk);
        check_one();
        @(posedge clk);
        #1;
    endtask

    task automatic run_r(input logic [5:0] fn, input string tag);
        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h00, fn, {tag, "_fetch"});
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h00, fn, {tag, "_decode"});
        cyc(T_REXEC,  1'b1, 1'b1, 1'b0, 6'h00, fn, {tag, "_rexec"});
        cyc(T_RWB,    1'b1, 1'b0, 1'b0, 6'h00, fn, {tag, "_rwb"});
    endtask

    task automatic run_i(input logic [5:0] op, input logic ovf, input string tag);
        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, op, 6'h3F, {tag, "_fetch"});
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, op, 6'h3F, {tag, "_decode"});
        cyc(T_IEXEC,  1'b1, 1'b0, ovf,  op, 6'h3F, {tag, "_iexec"});
        cyc(T_IWB,    1'b1, 1'b0, 1'b0, op, 6'h3F, {tag, "_iwb"});
    endtask

    task automatic run_br(input logic [5:0] op, input logic z, input string tag);
        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, op, 6'h00, {tag, "_fetch"});
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, op, 6'h00, {tag, "_decode"});
        cyc(T_BRANCH, 1'b1, z,    1'b0, op, 6'h00, {tag, "_branch"});
    endtask

    initial begin
        bus.mem_ready = 1'b0;
        bus.zero      = 1'b0;
        bus.overflow  = 1'b0;
        bus.opcode    = '0;
        bus.funct     = '0;
        rst_cyc("reset0");
        rst_cyc("reset1");

        cyc(T_FETCH, 1'b0, 1'b0, 1'b0, 6'h00, 6'h20, "fetch_wait0");
        cyc(T_FETCH, 1'b0, 1'b0, 1'b0, 6'h00, 6'h20, "fetch_wait1");
        run_r(6'h20, "add");
        run_r(6'h21, "addu");
        run_r(6'h22, "sub");
        run_r(6'h23, "subu");
        run_r(6'h24, "and");
        run_r(6'h25, "or");
        run_r(6'h27, "nor");
        run_r(6'h2A, "slt");
        run_r(6'h00, "sll");
        run_r(6'h02, "srl");

        run_i(6'h08, 1'b0, "addi");
        run_i(6'h09, 1'b1, "addiu_ovf");
        run_i(6'h0C, 1'b0, "andi");
        run_i(6'h0D, 1'b0, "ori");
        run_i(6'h0A, 1'b0, "slti");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h23, 6'h00, "lw_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, "lw_decode");
        cyc(T_MEMADR, 1'b1, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memadr");
        cyc(T_MEMRD,  1'b0, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memrd_w0");
        cyc(T_MEMRD,  1'b0, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memrd_w1");
        cyc(T_MEMRD,  1'b0, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memrd_w2");
        cyc(T_MEMRD,  1'b1, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memrd_done");
        cyc(T_MEMWB,  1'b1, 1'b0, 1'b0, 6'h23, 6'h00, "lw_memwb");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "sw_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "sw_decode");
        cyc(T_MEMADR, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "sw_memadr");
        cyc(T_MEMWR,  1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "sw_memwr");

        run_br(6'h04, 1'b1, "beq_taken");
        run_br(6'h04, 1'b0, "beq_not");
        run_br(6'h05, 1'b1, "bne_not");
        run_br(6'h05, 1'b0, "bne_taken");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h02, 6'h00, "j_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h02, 6'h00, "j_decode");
        cyc(T_JUMP,   1'b1, 1'b0, 1'b0, 6'h02, 6'h00, "j_jump");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h00, 6'h20, "addov_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h00, 6'h20, "addov_decode");
        cyc(T_REXEC,  1'b1, 1'b0, 1'b1, 6'h00, 6'h20, "addov_rexec");
        cyc(T_TRAP,   1'b1, 1'b0, 1'b0, 6'h00, 6'h20, "addov_trap");
        cyc(T_FETCH,  1'b1, 1'b0, 1'b1, 6'h00, 6'h21, "adduov_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b1, 6'h00, 6'h21, "adduov_decode");
        cyc(T_REXEC,  1'b1, 1'b0, 1'b1, 6'h00, 6'h21, "adduov_rexec");
        cyc(T_RWB,    1'b1, 1'b0, 1'b0, 6'h00, 6'h21, "adduov_rwb");
        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h00, 6'h22, "subov_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h00, 6'h22, "subov_decode");
        cyc(T_REXEC,  1'b1, 1'b0, 1'b1, 6'h00, 6'h22, "subov_rexec");
        cyc(T_TRAP,   1'b1, 1'b0, 1'b0, 6'h00, 6'h22, "subov_trap");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h08, 6'h00, "addiov_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h08, 6'h00, "addiov_decode");
        cyc(T_IEXEC,  1'b1, 1'b0, 1'b1, 6'h08, 6'h00, "addiov_iexec");
        cyc(T_TRAP,   1'b1, 1'b0, 1'b0, 6'h08, 6'h00, "addiov_trap");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, "illop_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, "illop_decode");
        cyc(T_TRAP,   1'b1, 1'b0, 1'b0, 6'h3F, 6'h00, "illop_trap");
        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h00, 6'h3F, "illfn_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h00, 6'h3F, "illfn_decode");
        cyc(T_REXEC,  1'b1, 1'b0, 1'b0, 6'h00, 6'h3F, "illfn_rexec");
        cyc(T_TRAP,   1'b1, 1'b0, 1'b0, 6'h00, 6'h3F, "illfn_trap");

        cyc(T_FETCH,  1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "swrst_fetch");
        cyc(T_DECODE, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "swrst_decode");
        cyc(T_MEMADR, 1'b1, 1'b0, 1'b0, 6'h2B, 6'h00, "swrst_memadr");
        cyc(T_MEMWR,  1'b0, 1'b0, 1'b0, 6'h2B, 6'h00, "swrst_memwr_w0");
        cyc(T_MEMWR,  1'b0, 1'b0, 1'b0, 6'h2B, 6'h00, "swrst_memwr_w1");
        rst_cyc("swrst_reset0");
        rst_cyc("swrst_reset1");
        cyc(T_FETCH,  1'b0, 1'b0, 1'b0, 6'h00, 6'h25, "post_rst_fetch_wait");
        run_r(6'h25, "post_rst_or");

        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain observed=%0d expected=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
